// File: rtl/mul_div_unit.sv
// HI/LO multiply/divide unit: multi-cycle signed/unsigned multiply and restoring divide,
// plus direct MTHI/MTLO writes, with cancel (pipeline flush) support.
module mul_div_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);
    localparam logic [CW-1:0] CNT_MUL_INIT = CW'(MUL_STAGES - 1);
    localparam logic [CW-1:0] CNT_DIV_INIT = CW'(WIDTH - 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        FIX  = 2'b11
    } state_t;

    state_t             state_r;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   quo_r;
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH-1:0]   dvs_r;
    logic               signed_r;
    logic               q_neg_r;
    logic               r_neg_r;
    logic               div_zero_r;
    logic [CW-1:0]      cnt_r;

    logic               accept_s;
    logic               s1_neg_s;
    logic               s2_neg_s;
    logic [WIDTH-1:0]   s1_mag_s;
    logic [WIDTH-1:0]   s2_mag_s;
    logic [2*WIDTH-1:0] ext_a_s;
    logic [2*WIDTH-1:0] ext_b_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH:0]     rem_shift_s;
    logic [WIDTH:0]     diff_s;
    logic [WIDTH-1:0]   quo_fix_s;
    logic [WIDTH-1:0]   rem_fix_s;

    assign in_ready = resetn && !busy_r && !cancel;
    assign busy     = busy_r;
    assign done     = done_r;
    assign hi       = hi_r;
    assign lo       = lo_r;

    // Operand magnitudes, multiplier product and one restoring-divide step.
    always_comb begin
        accept_s    = in_valid && in_ready;
        s1_neg_s    = !op[0] && src1[WIDTH-1];
        s2_neg_s    = !op[0] && src2[WIDTH-1];
        s1_mag_s    = s1_neg_s ? -src1 : src1;
        s2_mag_s    = s2_neg_s ? -src2 : src2;
        ext_a_s     = {{WIDTH{signed_r && a_r[WIDTH-1]}}, a_r};
        ext_b_s     = {{WIDTH{signed_r && b_r[WIDTH-1]}}, b_r};
        prod_s      = ext_a_s * ext_b_s;
        // Remainder stays below the divisor, so diff_s[WIDTH] is the borrow of the trial subtract.
        rem_shift_s = {rem_r, quo_r[WIDTH-1]};
        diff_s      = rem_shift_s - {1'b0, dvs_r};
        quo_fix_s   = q_neg_r ? -quo_r : quo_r;
        rem_fix_s   = r_neg_r ? -rem_r : rem_r;
    end

    // Control FSM with operand latches, divider datapath and HI/LO result registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            hi_r       <= '0;
            lo_r       <= '0;
            a_r        <= '0;
            b_r        <= '0;
            quo_r      <= '0;
            rem_r      <= '0;
            dvs_r      <= '0;
            signed_r   <= 1'b0;
            q_neg_r    <= 1'b0;
            r_neg_r    <= 1'b0;
            div_zero_r <= 1'b0;
            cnt_r      <= '0;
        end else begin
            done_r <= 1'b0;
            if (busy_r && cancel) begin
                state_r <= IDLE;
                busy_r  <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (accept_s) begin
                            case (op)
                                OP_MULT, OP_MULTU: begin
                                    state_r  <= MUL;
                                    busy_r   <= 1'b1;
                                    cnt_r    <= CNT_MUL_INIT;
                                    a_r      <= src1;
                                    b_r      <= src2;
                                    signed_r <= !op[0];
                                end
                                OP_DIV, OP_DIVU: begin
                                    state_r    <= DIV;
                                    busy_r     <= 1'b1;
                                    cnt_r      <= CNT_DIV_INIT;
                                    a_r        <= src1;
                                    quo_r      <= s1_mag_s;
                                    rem_r      <= '0;
                                    dvs_r      <= s2_mag_s;
                                    q_neg_r    <= s1_neg_s ^ s2_neg_s;
                                    r_neg_r    <= s1_neg_s;
                                    div_zero_r <= (src2 == '0);
                                end
                                OP_MTHI: hi_r    <= src1;
                                OP_MTLO: lo_r    <= src1;
                                default: state_r <= IDLE;
                            endcase
                        end
                    end
                    MUL: begin
                        if (cnt_r == '0) begin
                            {hi_r, lo_r} <= prod_s;
                            done_r       <= 1'b1;
                            state_r      <= IDLE;
                            busy_r       <= 1'b0;
                        end else begin
                            cnt_r <= cnt_r - CNT_ONE;
                        end
                    end
                    DIV: begin
                        rem_r <= diff_s[WIDTH] ? rem_shift_s[WIDTH-1:0] : diff_s[WIDTH-1:0];
                        quo_r <= {quo_r[WIDTH-2:0], !diff_s[WIDTH]};
                        if (cnt_r == '0) begin
                            state_r <= FIX;
                        end else begin
                            cnt_r <= cnt_r - CNT_ONE;
                        end
                    end
                    FIX: begin
                        // A zero divisor overrides the datapath result with the architectural pattern.
                        if (div_zero_r) begin
                            hi_r <= a_r;
                            lo_r <= '1;
                        end else begin
                            hi_r <= rem_fix_s;
                            lo_r <= quo_fix_s;
                        end
                        done_r  <= 1'b1;
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                    default: begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
